// File: rtl/keypad_code_lock_if.sv
// Signal bundle between the keypad scanner, the code lock and the display/buzzer side.
interface keypad_code_lock_if #(
  parameter int DIGITS = 3
) ();
  logic [15:0]                 onehot;
  logic [4*DIGITS-1:0]         display;
  logic [$clog2(DIGITS+1)-1:0] entered;
  logic [3:0]                  tries;
  logic                        unlocked;
  logic                        locked_out;
  logic                        buzzer;

  modport master (output onehot, input display, entered, tries, unlocked, locked_out, buzzer);
  modport slave  (input onehot, output display, entered, tries, unlocked, locked_out, buzzer);
endinterface

// File: rtl/keypad_code_lock.sv
// Keypad code lock: debounced-key decode, BCD code entry, try limit with lockout countdown,
// code change from the open state and a single prioritised buzzer tone engine.
module keypad_code_lock #(
  parameter int                  DIGITS       = 3,
  parameter int                  MAX_TRIES    = 3,
  parameter int                  LOCK_SECS    = 20,
  parameter int                  CLK_HZ       = 50_000_000,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 12'h246,
  parameter int                  TONE_KEY_DIV = 50000,
  parameter int                  TONE_OK_DIV  = 25000,
  parameter int                  TONE_ERR_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  keypad_code_lock_if.slave  bus
);

  localparam int DW         = 4*DIGITS;
  localparam int EW         = $clog2(DIGITS+1);
  localparam int TW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int LEN_KEY    = CLK_HZ/5;
  localparam int LEN_OK     = 3*CLK_HZ/5;
  localparam int LEN_ERR    = 3*CLK_HZ/10;
  localparam int ERR_GAP_LO = CLK_HZ/10;
  localparam int ERR_GAP_HI = LEN_ERR - CLK_HZ/10;
  localparam int NW         = $clog2(LEN_OK+1);
  localparam int DMAX_KO    = (TONE_KEY_DIV > TONE_OK_DIV) ? TONE_KEY_DIV : TONE_OK_DIV;
  localparam int DMAX       = (DMAX_KO > TONE_ERR_DIV) ? DMAX_KO : TONE_ERR_DIV;
  localparam int VW         = $clog2(DMAX+1);

  localparam logic [1:0] S_ENTRY   = 2'd0;
  localparam logic [1:0] S_OPEN    = 2'd1;
  localparam logic [1:0] S_SETCODE = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [3:0] K_ENTER = 4'd10;
  localparam logic [3:0] K_BKSP  = 4'd11;
  localparam logic [3:0] K_CLEAR = 4'd12;
  localparam logic [3:0] K_SET   = 4'd13;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_KEY  = 2'd1;
  localparam logic [1:0] T_OK   = 2'd2;
  localparam logic [1:0] T_ERR  = 2'd3;

  localparam logic [7:0]    LOCK_BCD = 8'(((LOCK_SECS/10) * 16) + (LOCK_SECS % 10));
  localparam logic [DW-1:0] BLANK    = {DIGITS{4'hF}};
  localparam logic [DW-1:0] OPEN_PAT = {DIGITS{4'hC}};

  // Returns {valid, code}; codes 0..9 are digits, 10..13 are the command keys.
  function automatic logic [4:0] decode(input logic [15:0] k);
    case (k)
      16'h0008: decode = {1'b1, 4'd0};
      16'h0080: decode = {1'b1, 4'd1};
      16'h0040: decode = {1'b1, 4'd2};
      16'h0020: decode = {1'b1, 4'd3};
      16'h0800: decode = {1'b1, 4'd4};
      16'h0400: decode = {1'b1, 4'd5};
      16'h0200: decode = {1'b1, 4'd6};
      16'h8000: decode = {1'b1, 4'd7};
      16'h4000: decode = {1'b1, 4'd8};
      16'h2000: decode = {1'b1, 4'd9};
      16'h0001: decode = {1'b1, K_ENTER};
      16'h1000: decode = {1'b1, K_BKSP};
      16'h0100: decode = {1'b1, K_CLEAR};
      16'h0010: decode = {1'b1, K_SET};
      default:  decode = 5'd0;
    endcase
  endfunction

  function automatic logic [DW-1:0] lock_disp(input logic [7:0] secs);
    logic [31:0] v;
    v = {24'hEEEEEE, secs};
    return v[DW-1:0];
  endfunction

  logic [15:0]   r_key, r_key_d;
  logic [1:0]    r_state;
  logic [DW-1:0] r_disp, r_code;
  logic [EW-1:0] r_entered;
  logic [3:0]    r_tries;
  logic [7:0]    r_secs;
  logic [TW-1:0] r_tick_cnt;
  logic          r_t_active, r_t_sq, r_buzzer;
  logic [1:0]    r_t_kind;
  logic [NW-1:0] r_t_dur;
  logic [VW-1:0] r_t_div;

  logic [4:0]    w_dec;
  logic [3:0]    w_key;
  logic          w_evt, w_full, w_match, w_tick;
  logic [DW-1:0] w_shl, w_shr;
  logic [7:0]    w_secs_dec;
  logic [1:0]    w_req;
  logic [NW-1:0] w_len, w_t_dur;
  logic [VW-1:0] w_half, w_t_div;
  logic          w_t_active, w_t_sq, w_aud, w_buzz;
  logic [1:0]    w_t_kind;

  assign w_dec   = decode(r_key);
  assign w_key   = w_dec[3:0];
  assign w_evt   = w_dec[4] && (r_key != r_key_d);
  assign w_full  = (r_entered == EW'(DIGITS));
  assign w_match = (r_disp == r_code);
  assign w_tick  = (r_tick_cnt == TW'(CLK_HZ-1));

  // Keypad sampling register and its one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key   <= 16'h0000;
      r_key_d <= 16'h0000;
    end else begin
      r_key   <= bus.onehot;
      r_key_d <= r_key;
    end
  end

  // Digit shift paths and BCD seconds decrement.
  always_comb begin
    w_shl            = r_disp << 4;
    w_shl[3:0]       = w_key;
    w_shr            = r_disp >> 4;
    w_shr[DW-1 -: 4] = 4'hF;
    if (r_secs[3:0] == 4'd0) begin
      w_secs_dec = {r_secs[7:4] - 4'd1, 4'd9};
    end else begin
      w_secs_dec = {r_secs[7:4], r_secs[3:0] - 4'd1};
    end
  end

  // Tone request for the current key event.
  always_comb begin
    w_req = T_NONE;
    if (w_evt && (r_state == S_ENTRY || r_state == S_SETCODE)) begin
      if (w_key <= 4'd9) begin
        if (!w_full) w_req = T_KEY;
        else         w_req = T_NONE;
      end else if (w_key == K_ENTER && w_full) begin
        if (r_state == S_SETCODE || w_match) w_req = T_OK;
        else                                 w_req = T_ERR;
      end else begin
        w_req = T_NONE;
      end
    end else begin
      w_req = T_NONE;
    end
  end

  // Lock state machine; lockout ignores every key, so keys and ticks never compete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ENTRY;
      r_disp     <= BLANK;
      r_entered  <= EW'(0);
      r_tries    <= 4'd0;
      r_code     <= DEFAULT_CODE;
      r_secs     <= 8'h00;
      r_tick_cnt <= TW'(0);
    end else begin
      r_tick_cnt <= w_tick ? TW'(0) : r_tick_cnt + TW'(1);
      if (r_state == S_LOCKOUT) begin
        if (w_tick) begin
          if (r_secs == 8'h00) begin
            r_state <= S_ENTRY;
            r_tries <= 4'd0;
            r_disp  <= BLANK;
          end else begin
            r_secs <= w_secs_dec;
            r_disp <= lock_disp(w_secs_dec);
          end
        end
      end else if (w_evt) begin
        case (w_key)
          K_ENTER: begin
            if (w_full && r_state != S_OPEN) begin
              r_disp    <= BLANK;
              r_entered <= EW'(0);
              if (r_state == S_SETCODE) begin
                r_code  <= r_disp;
                r_state <= S_ENTRY;
              end else if (w_match) begin
                r_state <= S_OPEN;
                r_tries <= 4'd0;
                r_disp  <= OPEN_PAT;
              end else if (r_tries + 4'd1 == 4'(MAX_TRIES)) begin
                r_state    <= S_LOCKOUT;
                r_tries    <= 4'(MAX_TRIES);
                r_secs     <= LOCK_BCD;
                r_disp     <= lock_disp(LOCK_BCD);
                r_tick_cnt <= TW'(0);
              end else begin
                r_tries <= r_tries + 4'd1;
              end
            end
          end
          K_BKSP: begin
            if (r_state != S_OPEN && r_entered != EW'(0)) begin
              r_disp    <= w_shr;
              r_entered <= r_entered - EW'(1);
            end
          end
          K_CLEAR: begin
            r_state   <= S_ENTRY;
            r_disp    <= BLANK;
            r_entered <= EW'(0);
          end
          K_SET: begin
            if (r_state == S_OPEN) begin
              r_state   <= S_SETCODE;
              r_disp    <= BLANK;
              r_entered <= EW'(0);
            end
          end
          default: begin
            if (w_key <= 4'd9 && r_state != S_OPEN && !w_full) begin
              r_disp    <= w_shl;
              r_entered <= r_entered + EW'(1);
            end
          end
        endcase
      end
    end
  end

  // Tone engine next state: a request restarts the tone; error tone is muted mid-way.
  always_comb begin
    case (r_t_kind)
      T_KEY:   begin w_len = NW'(LEN_KEY); w_half = VW'(TONE_KEY_DIV); end
      T_OK:    begin w_len = NW'(LEN_OK);  w_half = VW'(TONE_OK_DIV);  end
      T_ERR:   begin w_len = NW'(LEN_ERR); w_half = VW'(TONE_ERR_DIV); end
      default: begin w_len = NW'(1);       w_half = VW'(1);            end
    endcase
    w_t_active = r_t_active;
    w_t_kind   = r_t_kind;
    w_t_dur    = r_t_dur;
    w_t_div    = r_t_div;
    w_t_sq     = r_t_sq;
    if (w_req != T_NONE) begin
      w_t_active = 1'b1;
      w_t_kind   = w_req;
      w_t_dur    = NW'(0);
      w_t_div    = VW'(0);
      w_t_sq     = 1'b1;
    end else if (r_t_active) begin
      if (r_t_dur == w_len - NW'(1)) begin
        w_t_active = 1'b0;
        w_t_dur    = NW'(0);
        w_t_div    = VW'(0);
        w_t_sq     = 1'b0;
      end else begin
        w_t_dur = r_t_dur + NW'(1);
        if (r_t_div == w_half - VW'(1)) begin
          w_t_div = VW'(0);
          w_t_sq  = ~r_t_sq;
        end else begin
          w_t_div = r_t_div + VW'(1);
        end
      end
    end else begin
      w_t_sq = 1'b0;
    end
    w_aud  = (w_t_kind != T_ERR) || (w_t_dur < NW'(ERR_GAP_LO)) || (w_t_dur >= NW'(ERR_GAP_HI));
    w_buzz = w_t_active & w_t_sq & w_aud;
  end

  // Tone engine registers, including the registered buzzer drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t_active <= 1'b0;
      r_t_kind   <= T_NONE;
      r_t_dur    <= NW'(0);
      r_t_div    <= VW'(0);
      r_t_sq     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_t_active <= w_t_active;
      r_t_kind   <= w_t_kind;
      r_t_dur    <= w_t_dur;
      r_t_div    <= w_t_div;
      r_t_sq     <= w_t_sq;
      r_buzzer   <= w_buzz;
    end
  end

  assign bus.display    = r_disp;
  assign bus.entered    = r_entered;
  assign bus.tries      = r_tries;
  assign bus.unlocked   = (r_state == S_OPEN);
  assign bus.locked_out = (r_state == S_LOCKOUT);
  assign bus.buzzer     = r_buzzer;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Randomised self-checking bench for keypad_code_lock against a digit-queue reference model.
module tb_keypad_code_lock;
  localparam int CLK_HZ = 100;
  localparam int LOCK   = 20;
  localparam int MAXT   = 3;
  localparam int DKEY   = 4;
  localparam int DOK    = 3;
  localparam int DERR   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_code_lock_if #(.DIGITS(3)) bus ();

  keypad_code_lock #(
    .DIGITS(3), .MAX_TRIES(MAXT), .LOCK_SECS(LOCK), .CLK_HZ(CLK_HZ), .DEFAULT_CODE(12'h246),
    .TONE_KEY_DIV(DKEY), .TONE_OK_DIV(DOK), .TONE_ERR_DIV(DERR)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [20:0] act;
  assign act = {bus.display, bus.entered, bus.tries, bus.unlocked, bus.locked_out, bus.buzzer};

  logic [15:0] digit_key [10] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800,
                                  16'h0400, 16'h0200, 16'h8000, 16'h4000, 16'h2000};
  localparam logic [15:0] KEY_ENTER = 16'h0001;
  localparam logic [15:0] KEY_BKSP  = 16'h1000;
  localparam logic [15:0] KEY_CLEAR = 16'h0100;
  localparam logic [15:0] KEY_SET   = 16'h0010;

  // Reference model: typed digits (oldest first), code digits, tries, lock start, tone start.
  typedef enum {M_ENTRY, M_OPEN, M_SET, M_LOCK} mstate_t;
  mstate_t m_state;
  int m_digits[$];
  int m_code[$];
  int m_tries, m_lock_t0;
  bit m_t_on, m_t_err;
  int m_t_start, m_t_len, m_t_div;

  task automatic m_reset();
    m_state = M_ENTRY;
    m_digits.delete();
    m_code = '{2, 4, 6};
    m_tries = 0;
    m_t_on = 1'b0;
  endtask

  task automatic m_tone(input int len, input int div, input bit err, input int t0);
    m_t_on = 1'b1; m_t_len = len; m_t_div = div; m_t_err = err; m_t_start = t0;
  endtask

  task automatic m_advance(input int now);
    if (m_state == M_LOCK && now - m_lock_t0 >= (LOCK + 1) * CLK_HZ) begin
      m_state = M_ENTRY;
      m_tries = 0;
      m_digits.delete();
    end
  endtask

  function automatic int kval(input logic [15:0] k);
    for (int i = 0; i < 10; i++) if (digit_key[i] == k) return i;
    case (k)
      KEY_ENTER: return 10;
      KEY_BKSP:  return 11;
      KEY_CLEAR: return 12;
      KEY_SET:   return 13;
      default:   return -1;
    endcase
  endfunction

  function automatic bit code_eq();
    if (m_digits.size() != m_code.size()) return 1'b0;
    for (int i = 0; i < m_digits.size(); i++) if (m_digits[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Applies a key event whose outputs land after posedge number t.
  task automatic m_apply(input logic [15:0] k, input int t);
    int v;
    m_advance(t - 1);
    v = kval(k);
    if (v < 0 || m_state == M_LOCK) return;
    if (v <= 9) begin
      if ((m_state == M_ENTRY || m_state == M_SET) && m_digits.size() < 3) begin
        m_digits.push_back(v);
        m_tone(CLK_HZ / 5, DKEY, 1'b0, t);
      end
    end else if (v == 10) begin
      if ((m_state == M_ENTRY || m_state == M_SET) && m_digits.size() == 3) begin
        if (m_state == M_SET) begin
          m_code = m_digits;
          m_state = M_ENTRY;
          m_tone(3 * CLK_HZ / 5, DOK, 1'b0, t);
        end else if (code_eq()) begin
          m_state = M_OPEN;
          m_tries = 0;
          m_tone(3 * CLK_HZ / 5, DOK, 1'b0, t);
        end else begin
          m_tries++;
          m_tone(3 * CLK_HZ / 10, DERR, 1'b1, t);
          if (m_tries == MAXT) begin
            m_state = M_LOCK;
            m_lock_t0 = t;
          end
        end
        m_digits.delete();
      end
    end else if (v == 11) begin
      if ((m_state == M_ENTRY || m_state == M_SET) && m_digits.size() > 0) void'(m_digits.pop_back());
    end else if (v == 12) begin
      m_state = M_ENTRY;
      m_digits.delete();
    end else begin
      if (m_state == M_OPEN) begin
        m_state = M_SET;
        m_digits.delete();
      end
    end
  endtask

  function automatic logic m_buzz(input int now);
    int d;
    if (!m_t_on) return 1'b0;
    d = now - m_t_start;
    if (d < 0 || d >= m_t_len) return 1'b0;
    if (m_t_err && d >= CLK_HZ / 10 && d < 2 * CLK_HZ / 10) return 1'b0;
    return ((d / m_t_div) % 2) == 0;
  endfunction

  function automatic logic [20:0] m_pack(input int now);
    logic [11:0] disp;
    int secs;
    if (m_state == M_LOCK) begin
      secs = LOCK - (now - m_lock_t0) / CLK_HZ;
      disp = {4'hE, 4'(secs / 10), 4'(secs % 10)};
    end else if (m_state == M_OPEN) begin
      disp = 12'hCCC;
    end else begin
      disp = 12'hFFF;
      for (int i = 0; i < m_digits.size(); i++) disp[4*i +: 4] = 4'(m_digits[m_digits.size() - 1 - i]);
    end
    return {disp, 2'(m_digits.size()), 4'(m_tries), m_state == M_OPEN, m_state == M_LOCK, m_buzz(now)};
  endfunction

  task automatic press(input logic [15:0] k, input int hold);
    int t;
    @(negedge clk);
    bus.onehot = k;
    t = cyc + 2;
    repeat (hold) @(negedge clk);
    bus.onehot = 16'h0000;
    @(negedge clk);
    m_apply(k, t);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < target) begin
      n_tests++; n_fail++;
      $display("FAIL wait_bound: cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    bus.onehot = 16'h0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    n_tests++;
    if (act !== {12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset: got %h required %h", act, {12'hFFF, 2'd0, 4'd0, 3'b000});
    end
  endtask

  task automatic test_unlock();
    press(digit_key[2], 2);
    for (int i = 0; i < 24; i++) begin
      n_tests++;
      if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL click_tone: got %h required %h", act, m_pack(cyc)); end
      @(negedge clk);
    end
    press(digit_key[4], 2);
    press(digit_key[6], 2);
    press(KEY_ENTER, 2);
    n_tests++;
    if (act[20:3] !== {12'hCCC, 2'd0, 4'd0} || act[2:1] !== 2'b10) begin
      n_fail++; $display("FAIL unlock: got %h required CCC/open", act);
    end
    for (int i = 0; i < 64; i++) begin
      n_tests++;
      if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL ok_tone: got %h required %h", act, m_pack(cyc)); end
      @(negedge clk);
    end
    press(digit_key[5], 2);
    press(KEY_CLEAR, 2);
    n_tests++;
    if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL open_clear: got %h required %h", act, m_pack(cyc)); end
  endtask

  task automatic test_short_enter();
    press(digit_key[1], 2);
    press(digit_key[2], 3);
    press(KEY_ENTER, 2);
    n_tests++;
    if (act !== m_pack(cyc) || bus.entered !== 2'd2) begin
      n_fail++; $display("FAIL short_enter: got %h required %h", act, m_pack(cyc));
    end
    press(KEY_BKSP, 2);
    n_tests++;
    if (act !== m_pack(cyc) || bus.display !== 12'hFF1) begin
      n_fail++; $display("FAIL backspace: got %h required %h", act, m_pack(cyc));
    end
    press(KEY_CLEAR, 2);
  endtask

  task automatic test_hold_invalid();
    press(digit_key[1], 50);
    n_tests++;
    if (act !== m_pack(cyc) || bus.entered !== 2'd1) begin
      n_fail++; $display("FAIL hold: got %h required %h", act, m_pack(cyc));
    end
    press(16'h0090, 3);
    press(16'h0002, 3);
    press(16'h0004, 3);
    n_tests++;
    if (act !== m_pack(cyc) || bus.entered !== 2'd1) begin
      n_fail++; $display("FAIL invalid_keys: got %h required %h", act, m_pack(cyc));
    end
    press(KEY_CLEAR, 2);
  endtask

  task automatic test_lockout();
    for (int a = 0; a < MAXT; a++) begin
      for (int j = 0; j < 3; j++) press(digit_key[1], 2);
      press(KEY_ENTER, 2);
      if (a == 0) begin
        for (int i = 0; i < 32; i++) begin
          n_tests++;
          if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL err_tone: got %h required %h", act, m_pack(cyc)); end
          @(negedge clk);
        end
      end
      n_tests++;
      if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL wrong_code: got %h required %h", act, m_pack(cyc)); end
    end
    n_tests++;
    if (bus.display !== 12'hE20 || bus.locked_out !== 1'b1) begin
      n_fail++; $display("FAIL lock_entry: got %h required E20/locked", act);
    end
    press(digit_key[2], 2);
    press(KEY_CLEAR, 2);
    n_tests++;
    if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL lock_keys: got %h required %h", act, m_pack(cyc)); end
    wait_cyc(m_lock_t0 + CLK_HZ);
    n_tests++;
    if (act !== m_pack(cyc) || bus.display !== 12'hE19) begin
      n_fail++; $display("FAIL lock_tick: got %h required %h", act, m_pack(cyc));
    end
    wait_cyc(m_lock_t0 + (LOCK + 1) * CLK_HZ - 1);
    n_tests++;
    if (act !== m_pack(cyc) || bus.display !== 12'hE00) begin
      n_fail++; $display("FAIL lock_zero: got %h required %h", act, m_pack(cyc));
    end
    @(negedge clk);
    m_advance(cyc);
    n_tests++;
    if (act !== m_pack(cyc) || bus.display !== 12'hFFF || bus.tries !== 4'd0) begin
      n_fail++; $display("FAIL lock_exit: got %h required %h", act, m_pack(cyc));
    end
  endtask

  task automatic test_setcode();
    int seq [6][4] = '{'{2, 4, 6, -1}, '{-2, 9, 8, 7}, '{2, 4, 6, -1}, '{9, 8, 7, -1},
                       '{-2, 1, 2, -3}, '{9, 8, 7, -1}};
    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < 4; j++) begin
        if (seq[s][j] >= 0)       press(digit_key[seq[s][j]], 2);
        else if (seq[s][j] == -1) press(KEY_ENTER, 2);
        else if (seq[s][j] == -2) press(KEY_SET, 2);
        else                      press(KEY_CLEAR, 2);
        n_tests++;
        if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL setcode_%0d_%0d: got %h required %h", s, j, act, m_pack(cyc)); end
      end
    end
    press(digit_key[3], 2);
    press(KEY_CLEAR, 2);
    press(KEY_SET, 2);
    n_tests++;
    if (act !== m_pack(cyc) || bus.unlocked !== 1'b0) begin
      n_fail++; $display("FAIL set_in_entry: got %h required %h", act, m_pack(cyc));
    end
  endtask

  task automatic test_random();
    int r;
    int code_copy[$];
    logic [15:0] k;
    for (int it = 0; it < 120; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 19) begin
        code_copy = m_code;
        for (int j = 0; j < code_copy.size(); j++) press(digit_key[code_copy[j]], 2);
        k = KEY_ENTER;
      end else if (r < 10) k = digit_key[r];
      else if (r < 12)     k = KEY_ENTER;
      else if (r == 12)    k = KEY_BKSP;
      else if (r == 13)    k = KEY_CLEAR;
      else if (r <= 15)    k = KEY_SET;
      else if (r == 16)    k = 16'h0002;
      else if (r == 17)    k = 16'h0004;
      else                 k = 16'h0090;
      press(k, int'($urandom_range(2, 5)));
      n_tests++;
      if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL random_%0d: key %h got %h required %h", it, k, act, m_pack(cyc)); end
      if (m_state == M_LOCK) begin
        wait_cyc(m_lock_t0 + (LOCK + 1) * CLK_HZ);
        m_advance(cyc);
        n_tests++;
        if (act !== m_pack(cyc)) begin n_fail++; $display("FAIL random_unlock_%0d: got %h required %h", it, act, m_pack(cyc)); end
      end
    end
  endtask

  task automatic test_reset_lockout();
    test_reset();
    for (int a = 0; a < MAXT; a++) begin
      for (int j = 0; j < 3; j++) press(digit_key[1], 2);
      press(KEY_ENTER, 2);
    end
    wait_cyc(m_lock_t0 + 13 * CLK_HZ);
    n_tests++;
    if (act !== m_pack(cyc) || bus.display !== 12'hE07) begin
      n_fail++; $display("FAIL lock_07: got %h required %h", act, m_pack(cyc));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    n_tests++;
    if (act !== {12'hFFF, 2'd0, 4'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_in_lock: got %h required %h", act, {12'hFFF, 2'd0, 4'd0, 3'b000});
    end
    press(digit_key[2], 2);
    press(digit_key[4], 2);
    press(digit_key[6], 2);
    press(KEY_ENTER, 2);
    n_tests++;
    if (act !== m_pack(cyc) || bus.unlocked !== 1'b1) begin
      n_fail++; $display("FAIL default_code: got %h required %h", act, m_pack(cyc));
    end
    press(KEY_CLEAR, 2);
    press(digit_key[5], 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    n_tests++;
    if (act !== {12'hFFF, 2'd0, 4'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_mid_tone: got %h required %h", act, {12'hFFF, 2'd0, 4'd0, 3'b000});
    end
  endtask

  initial begin
    bus.onehot = 16'h0000;
    m_reset();
    test_reset();
    test_unlock();
    test_short_enter();
    test_hold_invalid();
    test_lockout();
    test_setcode();
    test_random();
    test_reset_lockout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
